// File: rtl/bp_table_scheduler.sv
// Shares the single branch-predictor table port between fetch lookups, queued execute updates and a clear sweep.
// Optional starvation guard for queued updates: define BP_STARVE_GUARD_EN.
module bp_table_scheduler #(
    parameter int IDX_WIDTH    = 4,
    parameter int FIFO_DEPTH   = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush_req,
    input  logic                            lkp_req,
    input  logic [IDX_WIDTH-1:0]            lkp_idx,
    output logic                            lkp_gnt,
    input  logic                            upd_valid,
    input  logic [IDX_WIDTH-1:0]            upd_idx,
    input  logic                            upd_taken,
    output logic                            upd_ready,
    output logic [$clog2(FIFO_DEPTH):0]     upd_count,
    output logic                            tbl_en,
    output logic                            tbl_we,
    output logic                            tbl_clr,
    output logic [IDX_WIDTH-1:0]            tbl_idx,
    output logic                            tbl_taken,
    output logic                            init_busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic {INIT = 1'b0, RUN = 1'b1} state_t;

    state_t               state, next_state;
    logic [IDX_WIDTH-1:0] sweep_cnt;
    logic [IDX_WIDTH-1:0] fifo_idx   [FIFO_DEPTH];
    logic                 fifo_taken [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 full, empty, push, pop, starve_hit;

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign upd_count = count;
    // Update handshake: an entry transfers in any cycle where upd_valid && upd_ready;
    // upd_ready reflects current occupancy only, so a same-cycle pop never frees a slot.
    assign push      = upd_valid && upd_ready;

`ifdef BP_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    assign starve_hit = !empty && (starve_cnt == 8'(STARVE_LIMIT));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_cnt <= '0;
        end else if (flush_req || pop || empty) begin
            starve_cnt <= '0;
        end else if (lkp_gnt && (starve_cnt != 8'hFF)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end
`else
    assign starve_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= INIT;
        end else if (flush_req) begin
            state <= INIT;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        lkp_gnt    = 1'b0;
        upd_ready  = 1'b0;
        pop        = 1'b0;
        tbl_en     = 1'b0;
        tbl_we     = 1'b0;
        tbl_clr    = 1'b0;
        tbl_idx    = '0;
        tbl_taken  = 1'b0;
        init_busy  = 1'b0;
        case (state)
            INIT: begin
                init_busy = 1'b1;
                tbl_en    = 1'b1;
                tbl_we    = 1'b1;
                tbl_clr   = 1'b1;
                tbl_idx   = sweep_cnt;
                if (sweep_cnt == {IDX_WIDTH{1'b1}}) begin
                    next_state = RUN;
                end
            end
            RUN: begin
                upd_ready = !full;
                if (full || starve_hit) begin
                    pop = 1'b1;
                end else if (lkp_req) begin
                    lkp_gnt = 1'b1;
                    tbl_en  = 1'b1;
                    tbl_idx = lkp_idx;
                end else if (!empty) begin
                    pop = 1'b1;
                end
                if (pop) begin
                    tbl_en    = 1'b1;
                    tbl_we    = 1'b1;
                    tbl_idx   = fifo_idx[rd_ptr];
                    tbl_taken = fifo_taken[rd_ptr];
                end
            end
            default: next_state = INIT;
        endcase
    end

    // Sweep counter wraps to 0 on its last step, which is also the RUN entry point.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sweep_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else if (flush_req) begin
            sweep_cnt <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
        end else begin
            if (state == INIT) begin
                sweep_cnt <= sweep_cnt + IDX_WIDTH'(1);
            end
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush_req) begin
            fifo_idx[wr_ptr]   <= upd_idx;
            fifo_taken[wr_ptr] <= upd_taken;
        end
    end

endmodule

// File: tb/tb_bp_table_scheduler.sv
// Directed bench for bp_table_scheduler with default parameters; tracks queued updates in an expected queue.
module tb_bp_table_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic       flush_req;
    logic       lkp_req;
    logic [3:0] lkp_idx;
    logic       lkp_gnt;
    logic       upd_valid;
    logic [3:0] upd_idx;
    logic       upd_taken;
    logic       upd_ready;
    logic [2:0] upd_count;
    logic       tbl_en;
    logic       tbl_we;
    logic       tbl_clr;
    logic [3:0] tbl_idx;
    logic       tbl_taken;
    logic       init_busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0] exp_q[$];

    bp_table_scheduler dut (
        .clk(clk), .rst(rst), .flush_req(flush_req),
        .lkp_req(lkp_req), .lkp_idx(lkp_idx), .lkp_gnt(lkp_gnt),
        .upd_valid(upd_valid), .upd_idx(upd_idx), .upd_taken(upd_taken),
        .upd_ready(upd_ready), .upd_count(upd_count),
        .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_clr(tbl_clr), .tbl_idx(tbl_idx),
        .tbl_taken(tbl_taken), .init_busy(init_busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic offer(input logic [3:0] idx, input logic taken);
        upd_valid = 1'b1;
        upd_idx   = idx;
        upd_taken = taken;
        exp_q.push_back({idx, taken});
    endtask

    task automatic expect_issue(input string tag);
        logic [4:0] e;
        check({tag, "_qlen"}, (exp_q.size() > 0) ? 1 : 0, 1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 5'h0;
        check({tag, "_en"}, tbl_en, 1);
        check({tag, "_we"}, tbl_we, 1);
        check({tag, "_clr"}, tbl_clr, 0);
        check({tag, "_gnt"}, lkp_gnt, 0);
        check({tag, "_idx"}, tbl_idx, e[4:1]);
        check({tag, "_taken"}, tbl_taken, e[0]);
    endtask

    task automatic expect_sweep(input int k);
        check("sweep_idx", tbl_idx, k);
        check("sweep_clr", {tbl_en, tbl_we, tbl_clr}, 3'b111);
        check("sweep_busy", init_busy, 1);
        check("sweep_gnt", lkp_gnt, 0);
        check("sweep_ready", upd_ready, 0);
    endtask

    initial begin
        rst = 1'b0; flush_req = 1'b0; lkp_req = 1'b1; lkp_idx = 4'd7;
        upd_valid = 1'b0; upd_idx = '0; upd_taken = 1'b0;

        // reset values, held across a clock edge
        #3;
        check("rst_busy", init_busy, 1);
        check("rst_tbl", {tbl_en, tbl_we, tbl_clr}, 3'b111);
        check("rst_idx", tbl_idx, 0);
        check("rst_gnt", lkp_gnt, 0);
        check("rst_ready", upd_ready, 0);
        check("rst_count", upd_count, 0);
        check("rst_taken", tbl_taken, 0);
        @(posedge clk); #1;
        check("rst_hold_idx", tbl_idx, 0);
        rst = 1'b1;

        // clear sweep with lookups requested throughout
        for (int k = 0; k < 16; k++) begin
            settle();
            expect_sweep(k);
            tick();
        end
        settle();
        check("run_gnt", lkp_gnt, 1);
        check("run_busy", init_busy, 0);
        check("run_we", tbl_we, 0);
        check("run_idx", tbl_idx, 7);
        check("run_ready", upd_ready, 1);

        // single update with no lookup pressure
        lkp_req = 1'b0;
        offer(4'd5, 1'b1);
        settle();
        check("s2_ready", upd_ready, 1);
        check("s2_idle", tbl_en, 0);
        tick();
        upd_valid = 1'b0;
        settle();
        check("s2_count1", upd_count, 1);
        expect_issue("s2_issue");
        tick();
        settle();
        check("s2_count0", upd_count, 0);
        check("s2_idle2", tbl_en, 0);

        // one update under continuous lookups
        lkp_req = 1'b1; lkp_idx = 4'd3;
        offer(4'd9, 1'b0);
        settle();
        check("s3_push_gnt", lkp_gnt, 1);
        tick();
        upd_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            settle();
            check("s3_gnt", lkp_gnt, 1);
            check("s3_rd", tbl_we, 0);
            check("s3_ridx", tbl_idx, 3);
            tick();
        end
        settle();
`ifdef BP_STARVE_GUARD_EN
        expect_issue("s3_starve_issue");
        tick();
        settle();
        check("s3_resume_gnt", lkp_gnt, 1);
        check("s3_count0", upd_count, 0);
`else
        check("s3_nostarve_gnt", lkp_gnt, 1);
        check("s3_nostarve_cnt", upd_count, 1);
        tick();
        lkp_req = 1'b0;
        settle();
        expect_issue("s3_idle_issue");
        tick();
        lkp_req = 1'b1;
        settle();
        check("s3_resume_gnt", lkp_gnt, 1);
`endif

        // four back-to-back updates fill the FIFO
        for (int i = 1; i <= 4; i++) begin
            offer(4'(i), 1'(i % 2));
            settle();
            check("s4_ready", upd_ready, 1);
            check("s4_gnt", lkp_gnt, 1);
            check("s4_count", upd_count, i - 1);
            tick();
        end
        upd_valid = 1'b0;
        settle();
        check("s4_full_count", upd_count, 4);
        check("s4_full_ready", upd_ready, 0);
        expect_issue("s4_full_issue");
        tick();
        settle();
        check("s4_ready_back", upd_ready, 1);
        check("s4_count3", upd_count, 3);
        check("s4_gnt_back", lkp_gnt, 1);
        tick();
        lkp_req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            expect_issue("s4_drain");
            tick();
        end
        settle();
        check("s4_empty", upd_count, 0);

        // simultaneous push/pop at occupancy 2, across pointer wrap
        lkp_req = 1'b1;
        offer(4'd10, 1'b1);
        settle();
        tick();
        offer(4'd11, 1'b0);
        settle();
        check("s5_gnt", lkp_gnt, 1);
        tick();
        lkp_req = 1'b0;
        for (int i = 0; i < 4; i++) begin
            offer(4'(12 + i), 1'(i % 2));
            settle();
            check("s5_count2", upd_count, 2);
            check("s5_ready", upd_ready, 1);
            expect_issue("s5_order");
            tick();
        end
        upd_valid = 1'b0;
        settle();
        check("s5_count2_last", upd_count, 2);
        expect_issue("s5_tail0");
        tick();
        settle();
        check("s5_count1", upd_count, 1);
        expect_issue("s5_tail1");
        tick();
        settle();
        check("s5_count0", upd_count, 0);
        check("s5_qempty", exp_q.size(), 0);

        // flush with three queued updates, then a second flush mid-sweep
        lkp_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            offer(4'(6 + i), 1'b1);
            settle();
            tick();
        end
        upd_valid = 1'b1; upd_idx = 4'd15; upd_taken = 1'b1;
        flush_req = 1'b1;
        settle();
        check("s6_pre_count", upd_count, 3);
        tick();
        flush_req = 1'b0;
        upd_valid = 1'b0;
        exp_q.delete();
        settle();
        check("s6_busy", init_busy, 1);
        check("s6_count", upd_count, 0);
        for (int k = 0; k < 8; k++) begin
            settle();
            expect_sweep(k);
            if (k == 7) flush_req = 1'b1;
            tick();
        end
        flush_req = 1'b0;
        lkp_req = 1'b0;
        for (int k = 0; k < 16; k++) begin
            settle();
            expect_sweep(k);
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            settle();
            check("s6_no_stale_issue", tbl_en, 0);
            check("s6_busy_off", init_busy, 0);
            check("s6_count0", upd_count, 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/bp_table_scheduler.md
# bp_table_scheduler

Access scheduler for the single-ported branch-predictor tables (PHT / meta counters). It shares the table's one read/write port between fetch-stage lookups and resolved-branch updates from execute, buffering updates in a small FIFO. It also sequences a full-table clear sweep after reset or flush. It sits between fetch, execute, and the predictor arrays; the arrays do no arbitration of their own.

## Interface
- IDX_WIDTH, 4, table index width; the table has 2**IDX_WIDTH entries
- FIFO_DEPTH, 4, update FIFO entries; power of two, at least 2
- STARVE_LIMIT, 8, number of consecutive lookup grants allowed while an update waits; 1..255
- clk  input  1  clock
- rst  input  1  reset; one clock, reset is asynchronous and active-low
- flush_req  input  1  restart the clear sweep and discard pending updates
- lkp_req  input  1  fetch requests a table read
- lkp_idx  input  IDX_WIDTH  lookup index
- lkp_gnt  output  1  table port granted to the lookup this cycle
- upd_valid  input  1  execute offers a resolved branch
- upd_idx  input  IDX_WIDTH  index to update
- upd_taken  input  1  resolved direction
- upd_ready  output  1  FIFO accepts an update this cycle
- upd_count  output  $clog2(FIFO_DEPTH)+1  FIFO occupancy
- tbl_en  output  1  table port active
- tbl_we  output  1  write (update or clear); 0 means read
- tbl_clr  output  1  write the reset value (weakly-not-taken / use_local2)
- tbl_idx  output  IDX_WIDTH  port index
- tbl_taken  output  1  outcome for a counter update
- init_busy  output  1  clear sweep in progress

## Operation
- Two states: INIT and RUN.
- INIT: every cycle drive tbl_en=1, tbl_we=1, tbl_clr=1, tbl_idx=sweep_cnt, then increment sweep_cnt. After the cycle with sweep_cnt = 2**IDX_WIDTH-1, go to RUN. lkp_gnt=0, upd_ready=0, init_busy=1.
- RUN: one port access per cycle, chosen in this order:
  1. Update, if FIFO is full.
  2. Update, if FIFO is non-empty and starve_cnt == STARVE_LIMIT.
  3. Lookup, if lkp_req=1.
  4. Update, if FIFO is non-empty.
  5. Otherwise tbl_en=0.
- Lookup access: tbl_en=1, tbl_we=0, tbl_idx=lkp_idx, lkp_gnt=1.
- Update access: pop the FIFO head; tbl_en=1, tbl_we=1, tbl_clr=0, tbl_idx=head idx, tbl_taken=head taken.
- starve_cnt:
  - Cleared on any update issue, or whenever the FIFO is empty.
  - Increments (saturating) on each lookup grant made while the FIFO is non-empty.
- FIFO:
  - Push when upd_valid && upd_ready.
  - upd_ready = RUN && !full. It depends only on current occupancy; a same-cycle pop does not free a slot.
  - Push and pop in the same cycle: occupancy is unchanged.
  - There is no bypass. An entry is popped no earlier than the cycle after it is pushed.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- flush_req in either state takes effect at the next edge:
  - state becomes INIT, sweep_cnt=0, FIFO emptied, starve_cnt=0.
  - The current cycle's push is discarded.
  - flush_req during INIT restarts the sweep at 0.
- No same-index hazard handling: a lookup that collides with a queued update reads the stale counter.

## Timing
- State after reset, and while rst=0: INIT, sweep_cnt=0, FIFO empty, starve_cnt=0.
- Output values at reset: init_busy=1, tbl_en=1, tbl_we=1, tbl_clr=1, tbl_idx=0, lkp_gnt=0, upd_ready=0, upd_count=0, tbl_taken=0.
- Sweep length: exactly 2**IDX_WIDTH cycles after rst deasserts. The first RUN cycle is cycle 2**IDX_WIDTH.
- lkp_gnt, upd_ready and all tbl_* outputs are combinational from registered state and the current request inputs. Table data returns one cycle after a granted read; that timing belongs to the table.
- Update latency is at least 1 cycle from acceptance to issue.
- Worst case with the starvation guard: STARVE_LIMIT+1 cycles from head-of-queue to issue.
- All registers are updated on the rising clk edge only; rst clears them asynchronously.

## Configuration
- BP_STARVE_GUARD_EN
  - Defined: rule 2 is active and starve_cnt is implemented.
  - Undefined: rule 2 and starve_cnt are removed. Updates issue only when the FIFO is full or when no lookup is requested, so updates may wait indefinitely while the FIFO is not full.

## Test plan
All scenarios use defaults (IDX_WIDTH=4, FIFO_DEPTH=4, STARVE_LIMIT=8).
- Reset, then hold lkp_req=1 → 16 cycles of clr writes with tbl_idx 0..15 and init_busy=1; lkp_gnt=1 first in cycle 16; upd_ready=0 throughout the sweep.
- In RUN with lkp_req=0, push (idx 5, taken 1) → next cycle tbl_we=1, tbl_idx=5, tbl_taken=1; upd_count returns to 0.
- lkp_req held at 1, push one update (guard enabled) → 8 lookup grants, then update issued on the 9th cycle, then lookups resume.
- lkp_req held at 1, push 4 updates back-to-back → upd_ready drops with count=4; the full FIFO forces an update the next cycle; ready rises the cycle after.
- Push and pop in the same cycle at count=2 → count stays 2; head order preserved across pointer wrap (push 6 entries total and check they issue in order).
- flush_req with 3 queued updates in RUN → next cycle init_busy=1, upd_count=0, tbl_idx=0; the queued updates are never issued; a second flush at sweep index 7 restarts at 0.
